// File: rtl/div_pkg.sv
// Shared definitions for the execute-stage multi-cycle divider.
// The counter-width helper is also used by the Booth multiplier.
package div_pkg;

  localparam int unsigned DIV_DATA_BITS = 33;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned res;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

  localparam int unsigned COUNT_BITS = clog2(DIV_DATA_BITS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } div_state_e;

endpackage

// File: rtl/div_sub_step.sv
// One radix-2 restoring step: shift in the next dividend bit and trial-subtract
// the divisor magnitude; a non-negative result is kept and yields quotient bit 1.
module div_sub_step
  import div_pkg::*;
#(
  parameter int unsigned DATA_BITS = DIV_DATA_BITS
) (
  input  logic [DATA_BITS-1:0] i_r,
  input  logic                 i_q_msb,
  input  logic [DATA_BITS-1:0] i_dvsr,
  output logic [DATA_BITS-1:0] o_r_next,
  output logic                 o_q_bit
);

  logic [DATA_BITS:0] w_trial;

  // The remainder stays below the divisor magnitude (<= 2^(DATA_BITS-1)), so
  // the shifted value fits and the trial's top bit is a true sign.
  assign w_trial  = {i_r, i_q_msb} - {1'b0, i_dvsr};
  assign o_q_bit  = ~w_trial[DATA_BITS];
  assign o_r_next = w_trial[DATA_BITS] ? {i_r[DATA_BITS-2:0], i_q_msb}
                                       : w_trial[DATA_BITS-1:0];

endmodule

// File: rtl/div.sv
// Sequential radix-2 restoring divider with RISC-V signed semantics.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero skips the iteration phase.
module div
  import div_pkg::*;
#(
  parameter int unsigned DATA_BITS = DIV_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 asyn_rst,
  input  logic                 syn_rst,
  input  logic                 en,
  input  logic [DATA_BITS-1:0] dividend,
  input  logic [DATA_BITS-1:0] divisor,
  output logic                 outvalid,
  output logic [DATA_BITS-1:0] quotient,
  output logic [DATA_BITS-1:0] remainder,
  output logic                 divzero
);

  localparam int unsigned CW = (clog2(DATA_BITS) > 0) ? clog2(DATA_BITS) : 1;

  div_state_e           r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_sign_q;
  logic                 r_sign_r;
  logic                 r_dz;
  logic [DATA_BITS-1:0] r_dvd;
  logic [DATA_BITS-1:0] r_dvsr;
  logic [DATA_BITS-1:0] r_q;
  logic [DATA_BITS-1:0] r_r;
  logic                 r_outvalid;
  logic [DATA_BITS-1:0] r_quotient;
  logic [DATA_BITS-1:0] r_remainder;
  logic                 r_divzero;

  logic [DATA_BITS-1:0] w_dvd_mag;
  logic [DATA_BITS-1:0] w_dvsr_mag;
  logic [DATA_BITS-1:0] w_r_next;
  logic                 w_q_bit;
  logic                 w_dvsr_zero;

  // Most-negative operand negates to itself, which reads as 2^(DATA_BITS-1) unsigned.
  assign w_dvd_mag   = dividend[DATA_BITS-1] ? (~dividend + DATA_BITS'(1)) : dividend;
  assign w_dvsr_mag  = divisor[DATA_BITS-1]  ? (~divisor + DATA_BITS'(1))  : divisor;
  assign w_dvsr_zero = (divisor == '0);

  div_sub_step #(
    .DATA_BITS(DATA_BITS)
  ) u_step (
    .i_r     (r_r),
    .i_q_msb (r_q[DATA_BITS-1]),
    .i_dvsr  (r_dvsr),
    .o_r_next(w_r_next),
    .o_q_bit (w_q_bit)
  );

  always_ff @(posedge clk or negedge asyn_rst) begin
    if (!asyn_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dz        <= 1'b0;
      r_dvd       <= '0;
      r_dvsr      <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_outvalid  <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divzero   <= 1'b0;
    end else if (syn_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dz        <= 1'b0;
      r_dvd       <= '0;
      r_dvsr      <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_outvalid  <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divzero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en) begin
            r_sign_q <= dividend[DATA_BITS-1] ^ divisor[DATA_BITS-1];
            r_sign_r <= dividend[DATA_BITS-1];
            r_dz     <= w_dvsr_zero;
            r_dvd    <= dividend;
            r_dvsr   <= w_dvsr_mag;
            r_q      <= w_dvd_mag;
            r_r      <= '0;
            r_cnt    <= '0;
`ifdef DIV_ZERO_FAST_EN
            r_state  <= w_dvsr_zero ? FIX : CALC;
`else
            r_state  <= CALC;
`endif
          end
        end
        CALC: begin
          if (en) begin
            r_r   <= w_r_next;
            r_q   <= {r_q[DATA_BITS-2:0], w_q_bit};
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(DATA_BITS - 1)) begin
              r_state <= FIX;
            end
          end
        end
        FIX: begin
          if (en) begin
            if (r_dz) begin
              r_quotient  <= '1;
              r_remainder <= r_dvd;
            end else begin
              r_quotient  <= r_sign_q ? (~r_q + DATA_BITS'(1)) : r_q;
              r_remainder <= r_sign_r ? (~r_r + DATA_BITS'(1)) : r_r;
            end
            r_divzero  <= r_dz;
            r_outvalid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          r_outvalid <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign outvalid  = r_outvalid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign divzero   = r_divzero;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases, stall/reset scenarios and
// randomized operands compared against a plain-arithmetic reference.
module tb_div;

  localparam int unsigned N       = 33;
  localparam int unsigned NOM_LAT = N + 1;

  logic         clk;
  logic         asyn_rst;
  logic         syn_rst;
  logic         en;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         outvalid;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         divzero;

  int unsigned n_checks;
  int unsigned n_pass;

  div #(.DATA_BITS(N)) dut (
    .clk      (clk),
    .asyn_rst (asyn_rst),
    .syn_rst  (syn_rst),
    .en       (en),
    .dividend (dividend),
    .divisor  (divisor),
    .outvalid (outvalid),
    .quotient (quotient),
    .remainder(remainder),
    .divzero  (divzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RISC-V division rules evaluated with 64-bit signed arithmetic.
  function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r);
    longint sa, sb;
    sa = a[N-1] ? (longint'(a) - 64'sh2_0000_0000) : longint'(a);
    sb = b[N-1] ? (longint'(b) - 64'sh2_0000_0000) : longint'(b);
    if (sb == 0) begin
      q = '1;
      r = a;
    end else begin
      q = N'(sa / sb);
      r = N'(sa % sb);
    end
  endfunction

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] eq, input logic [N-1:0] er,
                        input int unsigned stall_at, input int unsigned stall_len);
    int unsigned edges;
    int unsigned exp_lat;
    logic        seen;
    exp_lat = NOM_LAT;
`ifdef DIV_ZERO_FAST_EN
    if (b == '0) exp_lat = 1;
`endif
    exp_lat += stall_len;
    dividend = a;
    divisor  = b;
    en       = 1'b1;
    tick();
    dividend = N'({$urandom(), $urandom()});
    divisor  = N'({$urandom(), $urandom()});
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 200) begin
      en = !(edges >= stall_at && edges < stall_at + stall_len);
      tick();
      edges++;
      seen = outvalid;
    end
    check({tag, ".lat"}, 64'(edges), 64'(exp_lat));
    check({tag, ".q"}, 64'(quotient), 64'(eq));
    check({tag, ".r"}, 64'(remainder), 64'(er));
    check({tag, ".dz"}, 64'(divzero), 64'(b == '0));
    en = 1'b0;
    tick();
    check({tag, ".pulse"}, 64'(outvalid), 64'd0);
    check({tag, ".hold"}, 64'(quotient), 64'(eq));
  endtask

  task automatic watch_quiet(input string tag, input int unsigned cycles);
    int unsigned hits;
    hits = 0;
    for (int i = 0; i < int'(cycles); i++) begin
      tick();
      if (outvalid) hits++;
    end
    check(tag, 64'(hits), 64'd0);
  endtask

  initial begin
    logic [N-1:0] a, b, eq, er;
    logic [N-1:0] most_neg;
    n_checks = 0;
    n_pass   = 0;
    most_neg = {1'b1, {(N-1){1'b0}}};
    asyn_rst = 1'b0;
    syn_rst  = 1'b0;
    en       = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst.valid", 64'(outvalid), 64'd0);
    check("rst.q", 64'(quotient), 64'd0);
    check("rst.r", 64'(remainder), 64'd0);
    check("rst.dz", 64'(divzero), 64'd0);
    asyn_rst = 1'b1;
    tick();
    watch_quiet("idle.quiet", 3);

    run_op("d100_7", N'(100), N'(7), N'(14), N'(2), 0, 0);
    run_op("dm100_7", 33'h1_FFFF_FF9C, N'(7), 33'h1_FFFF_FFF2, 33'h1_FFFF_FFFE, 0, 0);
    run_op("d7_0", N'(7), N'(0), 33'h1_FFFF_FFFF, N'(7), 0, 0);
    run_op("stall", N'(100), N'(7), N'(14), N'(2), 10, 5);
    run_op("ovf", 33'h1_0000_0000, 33'h1_FFFF_FFFF, 33'h1_0000_0000, N'(0), 0, 0);

    // Synchronous reset mid-iteration, with en also high on that edge.
    dividend = N'(100);
    divisor  = N'(7);
    en       = 1'b1;
    tick();
    repeat (10) tick();
    syn_rst = 1'b1;
    tick();
    syn_rst = 1'b0;
    en      = 1'b0;
    check("srst.valid", 64'(outvalid), 64'd0);
    check("srst.q", 64'(quotient), 64'd0);
    check("srst.r", 64'(remainder), 64'd0);
    check("srst.dz", 64'(divzero), 64'd0);
    watch_quiet("srst.quiet", 40);

    run_op("d50_m3", N'(50), 33'h1_FFFF_FFFD, 33'h1_FFFF_FFF0, N'(2), 0, 0);

    // Asynchronous reset mid-iteration, applied and released between edges.
    dividend = 33'h1_FFFF_FF9C;
    divisor  = N'(0);
    en       = 1'b1;
    tick();
    repeat (15) tick();
    #2 asyn_rst = 1'b0;
    #1;
    check("arst.valid", 64'(outvalid), 64'd0);
    check("arst.q", 64'(quotient), 64'd0);
    check("arst.r", 64'(remainder), 64'd0);
    check("arst.dz", 64'(divzero), 64'd0);
    en = 1'b0;
    #2 asyn_rst = 1'b1;
    watch_quiet("arst.quiet", 40);

    run_op("d9_3", N'(9), N'(3), N'(3), N'(0), 0, 0);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = N'({$urandom(), $urandom()});
          b = N'({$urandom(), $urandom()});
        end
        1: begin
          a = N'({$urandom(), $urandom()});
          b = N'(32'($urandom_range(0, 32)) - 32'd16);
          b = {{(N-32){b[31]}}, b[31:0]};
        end
        2: begin
          a = N'(32'($urandom_range(0, 64)) - 32'd32);
          a = {{(N-32){a[31]}}, a[31:0]};
          b = N'({$urandom(), $urandom()});
        end
        default: begin
          case ($urandom_range(0, 3))
            0: begin a = most_neg; b = '1; end
            1: begin a = N'({$urandom(), $urandom()}); b = '0; end
            2: begin a = most_neg; b = N'(1); end
            default: begin a = '0; b = N'({$urandom(), $urandom()}); end
          endcase
        end
      endcase
      ref_div(a, b, eq, er);
      run_op($sformatf("rnd%0d", i), a, b, eq, er, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
